fetch_stream_unit: RTL and testbench
====================================

// Module: fetch_stream_unit
// PURPOSE
//  Buffered fetch stage. Keeps one cache line in a line buffer, streams sequential instructions from it into an
//  N-entry instruction queue and hands them to decode with a valid/ready handshake plus PC.
//  Goes to the instruction cache only on line-buffer miss; single outstanding request; drops stale responses
//  after a redirect. Sits between the core's branch-redirect source and decode.
// PARAMETERS
//  PC_WIDTH     32   program counter width (byte address)
//  INSTR_WIDTH  32   instruction width; PC step = 4
//  LINE_WIDTH  128   icache line width; INSTR_PER_LINE = LINE_WIDTH/INSTR_WIDTH (power of 2, >=2)
//  QUEUE_DEPTH   4   instruction queue entries (power of 2, >=2)
// PORTS
//  clock            in   1           core clock
//  reset            in   1           asynchronous, active-high reset
//  boot_addr        in   PC_WIDTH    fetch PC loaded on reset
//  take_branch      in   1           redirect strobe, single cycle
//  branch_pc        in   PC_WIDTH    redirect target, 4-byte aligned
//  decode_ready     in   1           decode accepts head entry this cycle
//  decode_valid     out  1           queue head valid
//  decode_instr     out  INSTR_WIDTH queue head instruction
//  decode_pc        out  PC_WIDTH    queue head PC
//  icache_ready     in   1           icache can accept a request
//  icache_req_valid out  1           line request
//  icache_req_addr  out  PC_WIDTH    line-aligned address (low OFS bits zero)
//  icache_rsp_valid in   1           line response, single cycle
//  icache_rsp_data  in   LINE_WIDTH  line data; word i at bits [INSTR_WIDTH*i +: INSTR_WIDTH]
// BEHAVIOUR
//  - Reset: fetch_pc=boot_addr, queue empty, line buffer invalid, state IDLE, drop flag 0. All outputs 0.
//  - OFS=log2(LINE_WIDTH/8). line_hit = lb_valid && lb_tag==fetch_pc[PC_WIDTH-1:OFS].
//    word = fetch_pc[OFS-1:2]. fetch_pc+4 wraps modulo 2^PC_WIDTH. Low 2 bits of fetch_pc ignored.
//  - Push: line_hit && !take_branch && (!full || pop) -> enqueue {fetch_pc, word}; fetch_pc += 4.
//    Max one push per cycle.
//  - Pop: decode_valid && decode_ready. decode_* come combinationally from the queue head; valid = !empty.
//  - State IDLE: icache_req_valid = !line_hit && !take_branch (comb.).
//    Address = {fetch_pc[PC_WIDTH-1:OFS], 0}. Request accepted when icache_ready -> WAIT.
//  - State WAIT: icache_req_valid=0. On icache_rsp_valid:
//    - drop==0 && !take_branch: fill line buffer, set lb_tag, lb_valid=1.
//    - Otherwise: data discarded.
//    - In both cases: drop cleared, state -> IDLE.
//  - icache_rsp_valid while IDLE is ignored.
//  - Redirect (take_branch) has priority over everything in the cycle:
//    - fetch_pc <= branch_pc; queue flushed (same-cycle pop still counts as consumed).
//    - No push; no request issued.
//    - If WAIT: drop <= 1 (new request only after stale rsp returns).
//    - Line buffer retained; redirect into the buffered line needs no icache access.
//  - Latency:
//    - Redirect hit: redirect cycle N -> push in N+1 -> decode_valid in N+2.
//    - Miss: rsp cycle M -> fill -> push in M+1 -> decode_valid in M+2.
//    - Steady state: 1 instr/cycle.
//  - Queue full with decode stalled: fetch_pc holds, no push. No loss and no duplication of entries.
//  - Async reset mid-WAIT: returns to reset state immediately; later response ignored because state is IDLE.
// STRUCTURE
//  - fetch_pkg:
//    - fetch_entry_t {pc, instr}
//    - fetch_state_t {IDLE, WAIT}
//    - localparams OFS, WORD_IDX_W, PTR_W
//  - Sub-module fetch_instr_queue: sync FIFO of fetch_entry_t, QUEUE_DEPTH entries, with flush input.
//    Pointer+count design. Push accepted when full only if pop occurs in the same cycle.
//  - Top level: fetch_pc, line buffer, FSM, drop flag.
// TESTING (defaults, boot_addr=0x1000)
//  1. Reset, decode_ready=1: one req addr 0x1000; rsp words A,B,C,D ->
//     decode pc 0x1000..0x100C with instrs A..D on consecutive cycles, then req 0x1010.
//  2. decode_ready=0 after first line: queue holds 4 entries, decode_valid=1, no further push;
//     ready=1 -> A..D in order exactly once.
//  3. take_branch to 0x2008 while 0x1010 outstanding: no req until stale rsp returns; rsp dropped;
//     req 0x2000; decode pc 0x2008, 0x200C; then req 0x2010.
//  4. Line 0x1000 buffered, take_branch to 0x1004: no icache_req_valid;
//     decode_pc=0x1004 two cycles after redirect.
//  5. take_branch in same cycle as icache_rsp_valid: data dropped, lb_valid unchanged, queue empty next cycle,
//     req for branch line issued next cycle.
//  6. Assert reset in WAIT, then rsp arrives: all outputs 0 at once; rsp ignored; new req 0x1000 after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and derived constants for the buffered fetch stage.
// The default geometry here sizes the queue entry and line-buffer indexing.
package fetch_pkg;

   localparam int PC_W       = 32;
   localparam int INSTR_W    = 32;
   localparam int LINE_W     = 128;
   localparam int Q_DEPTH    = 4;

   localparam int OFS        = $clog2(LINE_W / 8);
   localparam int WORD_IDX_W = $clog2(LINE_W / INSTR_W);
   localparam int PTR_W      = $clog2(Q_DEPTH);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      IDLE,
      WAIT
   } fetch_state_t;

endpackage

// File: rtl/fetch_instr_queue.sv
// Synchronous instruction FIFO with flush; read/write pointers plus an occupancy count.
// A push while full is taken only when the head is popped in the same cycle.
module fetch_instr_queue
   import fetch_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   input  logic         flush_i,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   output fetch_entry_t head_o,
   output logic         empty_o,
   output logic         full_o
);

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok, pop_ok;
   fetch_entry_t     mem_q [Q_DEPTH];

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (PTR_W+1)'(Q_DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && !flush_i && (!full_o || pop_ok);
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/fetch_stream_unit.sv
// Buffered fetch stage: one-line buffer feeding an instruction queue toward decode,
// with single-outstanding icache requests and stale-response dropping after redirects.
module fetch_stream_unit
   import fetch_pkg::*;
#(
   parameter int PC_WIDTH    = PC_W,
   parameter int INSTR_WIDTH = INSTR_W,
   parameter int LINE_WIDTH  = LINE_W,
   parameter int QUEUE_DEPTH = Q_DEPTH
)(
   input  logic                   clock,
   input  logic                   reset,
   input  logic [PC_WIDTH-1:0]    boot_addr,
   input  logic                   take_branch,
   input  logic [PC_WIDTH-1:0]    branch_pc,
   input  logic                   decode_ready,
   output logic                   decode_valid,
   output logic [INSTR_WIDTH-1:0] decode_instr,
   output logic [PC_WIDTH-1:0]    decode_pc,
   input  logic                   icache_ready,
   output logic                   icache_req_valid,
   output logic [PC_WIDTH-1:0]    icache_req_addr,
   input  logic                   icache_rsp_valid,
   input  logic [LINE_WIDTH-1:0]  icache_rsp_data
);

   localparam int INSTR_PER_LINE = LINE_WIDTH / INSTR_WIDTH;
   localparam int TAG_W          = PC_WIDTH - OFS;

   fetch_state_t                                   state_q, state_d;
   logic                                           drop_q, drop_d;
   logic [PC_WIDTH-1:0]                            fetch_pc_q, fetch_pc_d;
   logic                                           lb_valid_q;
   logic [TAG_W-1:0]                               lb_tag_q;
   logic [INSTR_PER_LINE-1:0][INSTR_WIDTH-1:0]     lb_data_q;

   logic                  line_hit;
   logic [WORD_IDX_W-1:0] word;
   logic                  push, pop, q_full, q_empty;
   logic                  req, fill;
   fetch_entry_t          push_entry, head;

   assign line_hit = lb_valid_q && (lb_tag_q == fetch_pc_q[PC_WIDTH-1:OFS]);
   assign word     = fetch_pc_q[OFS-1:2];
   assign pop      = decode_valid && decode_ready;
   assign push     = line_hit && !take_branch && (!q_full || pop);

   assign push_entry.pc    = fetch_pc_q;
   assign push_entry.instr = lb_data_q[word];

   fetch_instr_queue u_queue (
      .clock       (clock),
      .reset       (reset),
      .flush_i     (take_branch),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (decode_ready),
      .head_o      (head),
      .empty_o     (q_empty),
      .full_o      (q_full)
   );

   // Outputs are forced to zero while empty or in reset so nothing stale leaks out.
   assign decode_valid     = !q_empty;
   assign decode_instr     = decode_valid ? head.instr : '0;
   assign decode_pc        = decode_valid ? head.pc : '0;
   assign icache_req_valid = req && !reset;
   assign icache_req_addr  = icache_req_valid ? {fetch_pc_q[PC_WIDTH-1:OFS], {OFS{1'b0}}} : '0;

   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      req     = 1'b0;
      fill    = 1'b0;
      case (state_q)
         IDLE: begin
            req = !line_hit && !take_branch;
            if (req && icache_ready) state_d = WAIT;
         end
         WAIT: begin
            if (icache_rsp_valid) begin
               fill    = !drop_q && !take_branch;
               drop_d  = 1'b0;
               state_d = IDLE;
            end else if (take_branch) begin
               drop_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (take_branch)  fetch_pc_d = branch_pc;
      else if (push)    fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         drop_q     <= 1'b0;
         fetch_pc_q <= boot_addr;
         lb_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         drop_q     <= drop_d;
         fetch_pc_q <= fetch_pc_d;
         if (fill) lb_valid_q <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (fill) begin
         lb_tag_q  <= fetch_pc_q[PC_WIDTH-1:OFS];
         lb_data_q <= icache_rsp_data;
      end
   end

endmodule

// File: tb/tb_fetch_stream_unit.sv
// Directed bench for fetch_stream_unit: inputs change on the falling edge, outputs are
// checked 1ns later, so each check sees the state left by the preceding rising edge.
module tb_fetch_stream_unit;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [31:0]   boot_addr;
   logic          take_branch;
   logic [31:0]   branch_pc;
   logic          decode_ready;
   logic          decode_valid;
   logic [31:0]   decode_instr;
   logic [31:0]   decode_pc;
   logic          icache_ready;
   logic          icache_req_valid;
   logic [31:0]   icache_req_addr;
   logic          icache_rsp_valid;
   logic [127:0]  icache_rsp_data;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0]  w0 [4];
   logic [31:0]  w2 [4];
   logic [127:0] line0, line2, junk;

   fetch_stream_unit dut (
      .clock            (clock),
      .reset            (reset),
      .boot_addr        (boot_addr),
      .take_branch      (take_branch),
      .branch_pc        (branch_pc),
      .decode_ready     (decode_ready),
      .decode_valid     (decode_valid),
      .decode_instr     (decode_instr),
      .decode_pc        (decode_pc),
      .icache_ready     (icache_ready),
      .icache_req_valid (icache_req_valid),
      .icache_req_addr  (icache_req_addr),
      .icache_rsp_valid (icache_rsp_valid),
      .icache_rsp_data  (icache_rsp_data)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clock);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, " valid"}, decode_valid, 1'b0);
      chk({tag, " instr"}, decode_instr, 32'h0);
      chk({tag, " pc"}, decode_pc, 32'h0);
      chk({tag, " req"}, icache_req_valid, 1'b0);
      chk({tag, " addr"}, icache_req_addr, 32'h0);
   endtask

   task automatic chk_dec(input string tag, input logic [31:0] pc, input logic [31:0] instr);
      chk({tag, " valid"}, decode_valid, 1'b1);
      chk({tag, " pc"}, decode_pc, pc);
      chk({tag, " instr"}, decode_instr, instr);
   endtask

   task automatic chk_req(input string tag, input logic [31:0] addr);
      chk({tag, " req"}, icache_req_valid, 1'b1);
      chk({tag, " addr"}, icache_req_addr, addr);
   endtask

   initial begin
      w0[0] = 32'hAAAA0001; w0[1] = 32'hBBBB0002; w0[2] = 32'hCCCC0003; w0[3] = 32'hDDDD0004;
      w2[0] = 32'h20000000; w2[1] = 32'h20000001; w2[2] = 32'h20000002; w2[3] = 32'h20000003;
      line0 = {w0[3], w0[2], w0[1], w0[0]};
      line2 = {w2[3], w2[2], w2[1], w2[0]};
      junk  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

      boot_addr        = 32'h1000;
      take_branch      = 1'b0;
      branch_pc        = 32'h0;
      decode_ready     = 1'b1;
      icache_ready     = 1'b1;
      icache_rsp_valid = 1'b0;
      icache_rsp_data  = '0;

      // Reset state
      #1 reset = 1'b1;
      #1 chk_zero_outputs("reset");

      // 1: first line streams A..D, then next-line request
      nxt(); reset = 1'b0;
      #1 chk_req("t1 first req", 32'h1000);
      chk("t1 first valid", decode_valid, 1'b0);
      nxt(); #1 chk("t1 wait req", icache_req_valid, 1'b0);
      nxt(); icache_rsp_valid = 1'b1; icache_rsp_data = line0;
      nxt(); icache_rsp_valid = 1'b0;
      #1 chk("t1 fill valid", decode_valid, 1'b0);
      chk("t1 hit req", icache_req_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         nxt(); #1 chk_dec($sformatf("t1 word%0d", i), 32'h1000 + 32'(4 * i), w0[i]);
      end
      chk_req("t1 next req", 32'h1010);

      // 2: decode stalled, queue fills and holds; then drains A..D once
      decode_ready = 1'b0;
      nxt(); reset = 1'b1;
      nxt(); reset = 1'b0;
      #1 chk_req("t2 first req", 32'h1000);
      nxt();
      nxt(); icache_rsp_valid = 1'b1; icache_rsp_data = line0;
      nxt(); icache_rsp_valid = 1'b0;
      repeat (6) nxt();
      #1 chk_dec("t2 held", 32'h1000, w0[0]);
      decode_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #0 chk_dec($sformatf("t2 drain%0d", i), 32'h1000 + 32'(4 * i), w0[i]);
         nxt(); #1;
      end
      chk("t2 drained", decode_valid, 1'b0);

      // 3: redirect while 0x1010 outstanding; stale response dropped
      nxt(); take_branch = 1'b1; branch_pc = 32'h2008;
      #1 chk("t3 redirect req", icache_req_valid, 1'b0);
      nxt(); take_branch = 1'b0;
      #1 chk("t3 drop req a", icache_req_valid, 1'b0);
      nxt(); #1 chk("t3 drop req b", icache_req_valid, 1'b0);
      nxt(); icache_rsp_valid = 1'b1; icache_rsp_data = junk;
      #1 chk("t3 stale rsp req", icache_req_valid, 1'b0);
      nxt(); icache_rsp_valid = 1'b0;
      #1 chk_req("t3 branch req", 32'h2000);
      chk("t3 no stale push", decode_valid, 1'b0);
      nxt(); #1 chk("t3 wait req", icache_req_valid, 1'b0);
      nxt(); icache_rsp_valid = 1'b1; icache_rsp_data = line2;
      nxt(); icache_rsp_valid = 1'b0;
      #1 chk("t3 fill valid", decode_valid, 1'b0);
      nxt(); #1 chk_dec("t3 first", 32'h2008, w2[2]);
      nxt(); #1 chk_dec("t3 second", 32'h200C, w2[3]);
      chk_req("t3 next req", 32'h2010);
      decode_ready = 1'b0;

      // 6: reset during WAIT; response during and after reset ignored
      nxt(); #1 chk_dec("t6 pre held", 32'h200C, w2[3]);
      chk("t6 pre wait", icache_req_valid, 1'b0);
      reset = 1'b1;
      #1 chk_zero_outputs("t6 in reset");
      nxt(); icache_rsp_valid = 1'b1; icache_rsp_data = junk;
      #1 chk_zero_outputs("t6 rsp in reset");
      nxt(); icache_rsp_valid = 1'b0; reset = 1'b0; icache_ready = 1'b0; decode_ready = 1'b1;
      #1 chk_req("t6 release req", 32'h1000);
      nxt(); icache_rsp_valid = 1'b1; icache_rsp_data = junk;
      nxt(); icache_rsp_valid = 1'b0;
      #1 chk("t6 idle rsp ignored", decode_valid, 1'b0);
      chk_req("t6 still req", 32'h1000);
      nxt(); icache_ready = 1'b1;
      nxt(); icache_ready = 1'b0; icache_rsp_valid = 1'b1; icache_rsp_data = line0;
      nxt(); icache_rsp_valid = 1'b0;
      #1 chk("t6 fill valid", decode_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         nxt(); #1 chk_dec($sformatf("t6 word%0d", i), 32'h1000 + 32'(4 * i), w0[i]);
      end
      chk_req("t6 next req", 32'h1010);

      // 4: redirect into the buffered line, no icache traffic
      nxt(); take_branch = 1'b1; branch_pc = 32'h1004;
      #1 chk("t4 redirect req", icache_req_valid, 1'b0);
      nxt(); take_branch = 1'b0;
      #1 chk("t4 hit req", icache_req_valid, 1'b0);
      chk("t4 n+1 valid", decode_valid, 1'b0);
      nxt(); #1 chk_dec("t4 n+2", 32'h1004, w0[1]);
      chk("t4 n+2 req", icache_req_valid, 1'b0);
      nxt(); #1 chk_dec("t4 next", 32'h1008, w0[2]);
      nxt(); #1 chk_dec("t4 last", 32'h100C, w0[3]);
      chk_req("t4 next req", 32'h1010);
      decode_ready = 1'b0; icache_ready = 1'b1;

      // 5: redirect coincident with response; line buffer keeps line 0x1000
      nxt(); icache_ready = 1'b0;
      #1 chk_dec("t5 held", 32'h100C, w0[3]);
      chk("t5 wait req", icache_req_valid, 1'b0);
      nxt(); icache_rsp_valid = 1'b1; icache_rsp_data = junk;
      take_branch = 1'b1; branch_pc = 32'h3000;
      #1 chk("t5 redirect req", icache_req_valid, 1'b0);
      nxt(); icache_rsp_valid = 1'b0; take_branch = 1'b0; decode_ready = 1'b1;
      #1 chk("t5 flushed", decode_valid, 1'b0);
      chk_req("t5 branch req", 32'h3000);
      nxt(); take_branch = 1'b1; branch_pc = 32'h1008;
      #1 chk("t5 back req", icache_req_valid, 1'b0);
      nxt(); take_branch = 1'b0;
      #1 chk("t5 lb kept req", icache_req_valid, 1'b0);
      nxt(); #1 chk_dec("t5 lb kept", 32'h1008, w0[2]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
